// File: rtl/cpu_pkg.sv
// Shared CPU package: control-unit and interrupt-sequencer state encodings, common constants.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package cpu_pkg;

    // Control-unit pipeline states (existing definitions).
    typedef enum logic [2:0] {
        CU_FETCH,
        CU_DECODE,
        CU_EXEC,
        CU_MEM,
        CU_WB
    } cu_state_t;

    // Interrupt vector number width.
    localparam int VEC_W = 8;

    // Interrupt sequencer states.
    typedef enum logic [2:0] {
        IRQ_IDLE,
        IRQ_PUSH_PC,
        IRQ_PUSH_FL,
        IRQ_RD_VEC,
        IRQ_POP_FL,
        IRQ_POP_PC,
        IRQ_DONE
    } irq_state_t;

    // Word-align an address by clearing the byte-offset bits.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest-indexed asserted request wins.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: req (request lines), vld (any request set), idx (binary index of the winner, 0 when vld=0).
module irq_prio_enc
    import cpu_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               vld,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        vld = |req;
        idx = '0;
        // Scan from the top down so the last hit, the lowest index, wins.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/return sequencer: pushes PC/flags and fetches the vector, or pops flags/PC, then loads the core.
// Latency: with zero-wait memory, load is sampled 5 edges after an entry acceptance, 4 after a return acceptance.
// Backpressure: each memory beat holds req/we/addr/wdata stable until mem_ack; wait states are unbounded.
// Ports: irq_in/irq_ack (hardware lines and one-hot service pulse), boundary/sw_req/sw_num/ret_req (requests),
//        pc_in/sp_in/flags_in/ivt_in (core state), pc_out/sp_out/flags_out/load/busy (core update),
//        mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack (stack and vector-table memory port).
module irq_sequencer #(
    parameter int NUM_IRQ      = 8,
    parameter int IRQ_VEC_BASE = 32,
    parameter int IE_BIT       = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [NUM_IRQ-1:0] irq_ack,
    input  logic               boundary,
    input  logic               sw_req,
    input  logic [7:0]         sw_num,
    input  logic               ret_req,
    input  logic [31:0]        pc_in,
    input  logic [31:0]        sp_in,
    input  logic [31:0]        flags_in,
    input  logic [31:0]        ivt_in,
    output logic [31:0]        pc_out,
    output logic [31:0]        sp_out,
    output logic [31:0]        flags_out,
    output logic               load,
    output logic               busy,
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_ack
);
    import cpu_pkg::*;

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    irq_state_t         state;
    logic [31:0]        pc_l;
    logic [31:0]        sp_l;
    logic [31:0]        fl_l;
    logic [31:0]        ivt_l;
    logic [VEC_W-1:0]   vec_l;
    logic [31:0]        popped_fl;

    logic               hw_vld;
    logic [IDX_W-1:0]   hw_idx;
    logic [VEC_W-1:0]   hw_vec;
    logic               beat_done;
    logic [31:0]        pushed_fl;
    logic [31:0]        entry_fl;
    logic [31:0]        vec_addr;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_prio (
        .req (irq_in),
        .vld (hw_vld),
        .idx (hw_idx)
    );

    assign hw_vec    = VEC_W'(IRQ_VEC_BASE) + VEC_W'(hw_idx);
    assign beat_done = mem_req && mem_ack;

    // The vector number lives in the top byte of the stacked flags word.
    assign pushed_fl = {vec_l, fl_l[31-VEC_W:0]};
    assign vec_addr  = word_align(ivt_l + {{(32-VEC_W-2){1'b0}}, vec_l, 2'b00});

    // Handler runs with interrupts masked.
    always_comb begin
        entry_fl         = pushed_fl;
        entry_fl[IE_BIT] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IRQ_IDLE;
            busy      <= 1'b0;
            load      <= 1'b0;
            irq_ack   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pc_out    <= '0;
            sp_out    <= '0;
            flags_out <= '0;
            pc_l      <= '0;
            sp_l      <= '0;
            fl_l      <= '0;
            ivt_l     <= '0;
            vec_l     <= '0;
            popped_fl <= '0;
        end else begin
            load    <= 1'b0;
            irq_ack <= '0;
            case (state)
                IRQ_IDLE: begin
                    if (boundary && (sw_req || ret_req || (flags_in[IE_BIT] && hw_vld))) begin
                        pc_l    <= pc_in;
                        sp_l    <= sp_in;
                        fl_l    <= flags_in;
                        ivt_l   <= ivt_in;
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                        if (ret_req && !sw_req) begin
                            state     <= IRQ_POP_FL;
                            mem_we    <= 1'b0;
                            mem_addr  <= word_align(sp_in);
                            mem_wdata <= '0;
                        end else begin
                            state     <= IRQ_PUSH_PC;
                            mem_we    <= 1'b1;
                            mem_addr  <= word_align(sp_in - 32'd4);
                            mem_wdata <= pc_in;
                            if (sw_req) begin
                                vec_l <= sw_num;
                            end else begin
                                vec_l   <= hw_vec;
                                irq_ack <= NUM_IRQ'(1) << hw_idx;
                            end
                        end
                    end
                end
                IRQ_PUSH_PC: begin
                    if (beat_done) begin
                        state     <= IRQ_PUSH_FL;
                        mem_addr  <= word_align(sp_l - 32'd8);
                        mem_wdata <= pushed_fl;
                    end
                end
                IRQ_PUSH_FL: begin
                    if (beat_done) begin
                        state     <= IRQ_RD_VEC;
                        mem_we    <= 1'b0;
                        mem_addr  <= vec_addr;
                        mem_wdata <= '0;
                    end
                end
                IRQ_RD_VEC: begin
                    if (beat_done) begin
                        state     <= IRQ_DONE;
                        mem_req   <= 1'b0;
                        pc_out    <= word_align(mem_rdata);
                        sp_out    <= sp_l - 32'd8;
                        flags_out <= entry_fl;
                    end
                end
                IRQ_POP_FL: begin
                    if (beat_done) begin
                        state     <= IRQ_POP_PC;
                        popped_fl <= mem_rdata;
                        mem_addr  <= word_align(sp_l + 32'd4);
                    end
                end
                IRQ_POP_PC: begin
                    if (beat_done) begin
                        state     <= IRQ_DONE;
                        mem_req   <= 1'b0;
                        pc_out    <= word_align(mem_rdata);
                        sp_out    <= sp_l + 32'd8;
                        flags_out <= popped_fl;
                    end
                end
                IRQ_DONE: begin
                    // load lands in the first IDLE cycle, which can already accept.
                    state <= IRQ_IDLE;
                    busy  <= 1'b0;
                    load  <= 1'b1;
                end
                default: begin
                    state   <= IRQ_IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer with a table-driven memory responder and programmable wait states.
// Latency: n/a.
// Backpressure: memory acknowledge is held low for wait_n cycles at the start of every beat.
module tb_irq_sequencer;

    localparam int NUM_IRQ = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_ack;
    logic               boundary;
    logic               sw_req;
    logic [7:0]         sw_num;
    logic               ret_req;
    logic [31:0]        pc_in, sp_in, flags_in, ivt_in;
    logic [31:0]        pc_out, sp_out, flags_out;
    logic               load, busy;
    logic               mem_req, mem_we, mem_ack;
    logic [31:0]        mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;
    int wait_n = 0;
    int wcnt;

    // Beat log filled by run_seq.
    logic [31:0] b_addr [8];
    logic [31:0] b_dat  [8];
    logic        b_we   [8];
    int          nb;
    logic        busy_k0;

    always #5 clk = ~clk;

    irq_sequencer #(
        .NUM_IRQ      (NUM_IRQ),
        .IRQ_VEC_BASE (32),
        .IE_BIT       (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .irq_ack   (irq_ack),
        .boundary  (boundary),
        .sw_req    (sw_req),
        .sw_num    (sw_num),
        .ret_req   (ret_req),
        .pc_in     (pc_in),
        .sp_in     (sp_in),
        .flags_in  (flags_in),
        .ivt_in    (ivt_in),
        .pc_out    (pc_out),
        .sp_out    (sp_out),
        .flags_out (flags_out),
        .load      (load),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // Wait-state generator: ack rises after wait_n cycles of an outstanding request.
    always @(posedge clk) begin
        if (reset) wcnt <= 0;
        else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign mem_ack = (wcnt >= wait_n);

    // Read-only memory contents used by the directed tests.
    always_comb begin
        case (mem_addr)
            32'h0000_8090: mem_rdata = 32'h0000_3003;
            32'h0000_8014: mem_rdata = 32'h0000_0500;
            32'h0000_8084: mem_rdata = 32'h0000_0600;
            32'h0000_0FF8: mem_rdata = 32'h2400_0004;
            32'h0000_0FFC: mem_rdata = 32'h0000_0203;
            32'h0000_0080: mem_rdata = 32'h0000_0700;
            default:       mem_rdata = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present the request on one edge, then withdraw it; optionally drop irq_in too.
    task automatic accept(input logic clr_irq);
        @(negedge clk);
        boundary = 1'b1;
        @(posedge clk);
        #1;
        boundary = 1'b0;
        sw_req   = 1'b0;
        ret_req  = 1'b0;
        if (clr_irq) irq_in = '0;
    endtask

    // Follow a sequence to its load pulse; lat counts edges from acceptance to the edge sampling load.
    task automatic run_seq(output int lat, output logic [NUM_IRQ-1:0] ack_first,
                           output logic [NUM_IRQ-1:0] ack_or);
        logic        pw  = 1'b0;
        logic [31:0] pa  = '0;
        logic [31:0] pd  = '0;
        logic        pwe = 1'b0;
        lat       = -1;
        nb        = 0;
        ack_first = '0;
        ack_or    = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) begin
                ack_first = irq_ack;
                busy_k0   = busy;
            end
            ack_or |= irq_ack;
            if (pw) begin
                chk("stable_addr", mem_addr, pa);
                chk("stable_wdata", mem_wdata, pd);
                chk("stable_we", {31'b0, mem_we}, {31'b0, pwe});
            end
            pw  = mem_req && !mem_ack;
            pa  = mem_addr;
            pd  = mem_wdata;
            pwe = mem_we;
            if (mem_req && mem_ack && nb < 8) begin
                b_addr[nb] = mem_addr;
                b_dat[nb]  = mem_wdata;
                b_we[nb]   = mem_we;
                nb++;
            end
            if (load) begin
                lat = k + 1;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $error("FAIL load_timeout: observed no load within 200 cycles, expected a load pulse");
        end
    endtask

    int                 lat;
    logic [NUM_IRQ-1:0] ack_first, ack_or;
    logic               seen;

    initial begin
        reset    = 1'b1;
        irq_in   = '0;
        boundary = 1'b0;
        sw_req   = 1'b0;
        sw_num   = '0;
        ret_req  = 1'b0;
        pc_in    = '0;
        sp_in    = '0;
        flags_in = '0;
        ivt_in   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_load", {31'b0, load}, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_irq_ack", {24'b0, irq_ack}, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_sp_out", sp_out, 32'h0);
        chk("rst_flags_out", flags_out, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Hardware IRQ 4 entry, zero-wait memory; irq drops right after acceptance
        sp_in = 32'h1000; pc_in = 32'h200; flags_in = 32'h4; ivt_in = 32'h8000; irq_in = 8'h10;
        accept(1'b1);
        run_seq(lat, ack_first, ack_or);
        chk("e1_irq_ack", {24'b0, ack_first}, 32'h10);
        chk("e1_busy", {31'b0, busy_k0}, 32'h1);
        chk("e1_nbeats", nb, 3);
        chk("e1_w0_addr", b_addr[0], 32'hFFC);
        chk("e1_w0_data", b_dat[0], 32'h200);
        chk("e1_w0_we", {31'b0, b_we[0]}, 32'h1);
        chk("e1_w1_addr", b_addr[1], 32'hFF8);
        chk("e1_w1_data", b_dat[1], 32'h2400_0004);
        chk("e1_rd_addr", b_addr[2], 32'h8090);
        chk("e1_rd_we", {31'b0, b_we[2]}, 32'h0);
        chk("e1_sp_out", sp_out, 32'hFF8);
        chk("e1_flags_out", flags_out, 32'h2400_0000);
        chk("e1_pc_out", pc_out, 32'h3000);
        chk("e1_latency", lat, 5);
        chk("e1_busy_at_load", {31'b0, busy}, 32'h0);

        // Software request beats simultaneous IRQs; held IRQ 1 is serviced next
        @(negedge clk);
        sp_in = 32'h2000; pc_in = 32'h100; flags_in = 32'h4; irq_in = 8'h0A;
        sw_req = 1'b1; sw_num = 8'h05;
        accept(1'b0);
        run_seq(lat, ack_first, ack_or);
        chk("sw_irq_ack_none", {24'b0, ack_or}, 32'h0);
        chk("sw_fl_push", b_dat[1], 32'h0500_0004);
        chk("sw_rd_addr", b_addr[2], 32'h8014);
        chk("sw_pc_out", pc_out, 32'h500);
        chk("sw_flags_out", flags_out, 32'h0500_0000);
        accept(1'b1);
        run_seq(lat, ack_first, ack_or);
        chk("hw1_irq_ack", {24'b0, ack_first}, 32'h02);
        chk("hw1_fl_push", b_dat[1], 32'h2100_0004);
        chk("hw1_rd_addr", b_addr[2], 32'h8084);
        chk("hw1_pc_out", pc_out, 32'h600);

        // Three wait states per beat
        @(negedge clk);
        wait_n = 3;
        sp_in = 32'h1000; pc_in = 32'h200; flags_in = 32'h4; irq_in = 8'h10;
        accept(1'b1);
        run_seq(lat, ack_first, ack_or);
        chk("ws_latency", lat, 14);
        chk("ws_w0_addr", b_addr[0], 32'hFFC);
        chk("ws_w1_data", b_dat[1], 32'h2400_0004);
        chk("ws_rd_addr", b_addr[2], 32'h8090);
        chk("ws_sp_out", sp_out, 32'hFF8);
        wait_n = 0;

        // Return from interrupt
        @(negedge clk);
        sp_in = 32'hFF8; flags_in = 32'h0; ret_req = 1'b1;
        accept(1'b1);
        run_seq(lat, ack_first, ack_or);
        chk("ret_irq_ack_none", {24'b0, ack_or}, 32'h0);
        chk("ret_nbeats", nb, 2);
        chk("ret_rd0_addr", b_addr[0], 32'hFF8);
        chk("ret_rd1_addr", b_addr[1], 32'hFFC);
        chk("ret_pc_out", pc_out, 32'h200);
        chk("ret_flags_out", flags_out, 32'h2400_0004);
        chk("ret_sp_out", sp_out, 32'h1000);
        chk("ret_latency", lat, 4);

        // Interrupts masked: nothing is accepted
        @(negedge clk);
        flags_in = 32'h0; irq_in = 8'hFF; boundary = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen |= busy | mem_req | (|irq_ack);
        end
        chk("masked_no_accept", {31'b0, seen}, 32'h0);
        boundary = 1'b0; irq_in = '0;

        // Reset during PUSH_FL abandons the sequence
        @(negedge clk);
        sp_in = 32'h1000; pc_in = 32'h200; flags_in = 32'h4; ivt_in = 32'h8000; irq_in = 8'h10;
        accept(1'b1);
        @(negedge clk);
        chk("abort_push_pc_addr", mem_addr, 32'hFFC);
        @(negedge clk);
        chk("abort_push_fl_addr", mem_addr, 32'hFF8);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_mem_req", {31'b0, mem_req}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;
        seen = load;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen |= load;
        end
        chk("abort_no_load", {31'b0, seen}, 32'h0);

        // SP wrap-around on entry
        sp_in = 32'h4; pc_in = 32'h400; flags_in = 32'h4; ivt_in = 32'h0; irq_in = 8'h01;
        accept(1'b1);
        run_seq(lat, ack_first, ack_or);
        chk("wrap_w0_addr", b_addr[0], 32'h0);
        chk("wrap_w0_data", b_dat[0], 32'h400);
        chk("wrap_w1_addr", b_addr[1], 32'hFFFF_FFFC);
        chk("wrap_w1_data", b_dat[1], 32'h2000_0004);
        chk("wrap_rd_addr", b_addr[2], 32'h80);
        chk("wrap_sp_out", sp_out, 32'hFFFF_FFFC);
        chk("wrap_pc_out", pc_out, 32'h700);
        chk("wrap_flags_out", flags_out, 32'h2000_0000);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
IRQ_SEQUENCER -- requirements
Module: irq_sequencer

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of hardware interrupt lines (1..32).
REQ-002 Parameter IRQ_VEC_BASE, default 32, vector number assigned to irq_in[0]; irq_in[i] maps to IRQ_VEC_BASE+i.
REQ-003 Parameter IE_BIT, default 2, index of the interrupt-enable bit in the flags word.
REQ-004 Ports: clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-005 Ports: irq_in in NUM_IRQ, level-sensitive requests; irq_ack out NUM_IRQ, one-hot one-cycle pulse for the IRQ being serviced.
REQ-006 Ports: boundary in 1, core is between instructions; sw_req in 1, software INT or exception; sw_num in 8, its vector; ret_req in 1, return-from-interrupt.
REQ-007 Ports: pc_in, sp_in, flags_in, ivt_in in 32 each, current core PC, SP (r29), flags (r31), vector table base.
REQ-008 Ports: pc_out, sp_out, flags_out out 32 each, new core values; load out 1, one-cycle pulse telling the core to take all three; busy out 1.
REQ-009 Ports: mem_req out 1; mem_we out 1; mem_addr out 32; mem_wdata out 32; mem_rdata in 32; mem_ack in 1.

Function
REQ-010 States: IDLE, PUSH_PC, PUSH_FL, RD_VEC, POP_FL, POP_PC, DONE; busy is high in every state except IDLE.
REQ-011 Acceptance in IDLE only, when boundary=1; priority is sw_req, then ret_req, then a hardware IRQ (only if flags_in[IE_BIT]=1); among IRQs, the lowest index wins.
REQ-012 On acceptance, latch pc_in, sp_in, flags_in, ivt_in and the vector number; later changes on these inputs are ignored until IDLE.
REQ-013 irq_ack[i] pulses in the cycle after acceptance of hardware IRQ i; sw_req and ret_req produce no irq_ack.
REQ-014 Entry sequence: PUSH_PC writes the latched PC to SP-4. PUSH_FL writes to SP-8 the latched flags with bits[31:24] replaced by the vector. RD_VEC reads from ivt+4*vector. DONE follows.
REQ-015 Return sequence: POP_FL reads flags from SP. POP_PC reads PC from SP+4. DONE follows.
REQ-016 Memory handshake: mem_req, mem_we, mem_addr and mem_wdata stay stable while mem_req=1 and mem_ack=0. A beat completes in the cycle where mem_req=1 and mem_ack=1. The next beat starts in the following cycle. Wait states are unbounded.
REQ-017 mem_addr[1:0] is always 00; SP and the vector table address are word-aligned by truncation.
REQ-018 In DONE, load pulses for one cycle and the FSM returns to IDLE; the earliest next acceptance is the cycle after DONE.
REQ-019 Entry results: sp_out=SP-8; pc_out={rdata[31:2],00}; flags_out=latched flags with [31:24]=vector and [IE_BIT]=0.
REQ-020 Return results: sp_out=SP+8; pc_out={popped PC[31:2],00}; flags_out=popped flags, unmodified.
REQ-021 Latency with mem_ack tied high: entry takes 5 cycles from the acceptance edge to the load pulse; return takes 4.
REQ-022 SP arithmetic is modulo 2^32: wrap-around is legal and not flagged.
REQ-023 An IRQ that deasserts after acceptance is still serviced. An IRQ that is held remains pending and is re-evaluated at the next IDLE acceptance.

Reset
REQ-024 Reset forces IDLE and drives busy, load, mem_req, mem_we and irq_ack to 0. It drives pc_out, sp_out, flags_out, mem_addr and mem_wdata to 0.
REQ-025 Reset during any non-IDLE state abandons the sequence: no load pulse occurs, and mem_req is 0 from the cycle after reset is sampled.

Structure
REQ-026 State encodings and the VEC_W=8 constant belong in the shared CPU package, alongside the existing control-unit state definitions.
REQ-027 One sub-module, irq_prio_enc: parametrised NUM_IRQ priority encoder producing a valid bit and a binary index.

Verification
REQ-028 Test: sp_in=0x1000, pc_in=0x200, flags_in=0x4, ivt_in=0x8000, irq_in=0x10, mem_ack=1. Required: writes 0x200@0xFFC and 0x24000004@0xFF8, then a read @0x8090. Then load with sp_out=0xFF8, flags_out=0x24000000.
REQ-029 Test: irq_in=0x0A and sw_req=1 with sw_num=0x05 in the same cycle. Required: vector 5 is serviced and irq_ack stays 0. The next sequence services irq_in[1] (vector 33).
REQ-030 Test: mem_ack held low for 3 cycles on each beat. Required: address and data are stable throughout each wait, and the load pulse comes 9 cycles later than the zero-wait case.
REQ-031 Test: ret_req with sp_in=0xFF8, memory 0xFF8=0x24000004, 0xFFC=0x203. Required: pc_out=0x200, flags_out=0x24000004, sp_out=0x1000.
REQ-032 Test: flags_in[2]=0 with irq_in=0xFF. Required: no acceptance. Separately, reset asserted during PUSH_FL: required no load pulse and mem_req=0 on the next cycle.
REQ-033 Test: sp_in=0x4 on entry. Required: writes at 0x0 and 0xFFFFFFFC, and sp_out=0xFFFFFFFC.
